// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I core: word-addressed data RAM with byte/half
// stores, plus an MMIO block (GPIO, prescaled timer with compare irq, sticky status).
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int GPIO_W      = 16
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic [31:0]       mem_address,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       mem_data_write,
   input  logic [2:0]        funct3,
   output logic [31:0]       chosen_read_data,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              timer_irq,
   output logic              misaligned_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
   localparam logic [7:0] OFF_GPIO_IN  = 8'h04;
   localparam logic [7:0] OFF_MTIME    = 8'h08;
   localparam logic [7:0] OFF_MTIMECMP = 8'h0C;
   localparam logic [7:0] OFF_STATUS   = 8'h10;
   localparam logic [7:0] OFF_PRESCALE = 8'h14;

   logic [31:0]       ram_q [DEPTH_WORDS];

   logic [GPIO_W-1:0] gpio_out_q,  gpio_out_d;
   logic [GPIO_W-1:0] gpio_s1_q;
   logic [GPIO_W-1:0] gpio_s2_q;
   logic [31:0]       mtime_q,     mtime_d;
   logic [31:0]       mtimecmp_q,  mtimecmp_d;
   logic [15:0]       prescale_q,  prescale_d;
   logic [15:0]       presc_cnt_q, presc_cnt_d;
   logic [1:0]        status_q,    status_d;

   logic [AW-1:0]     ram_idx;
   logic [7:0]        mmio_off;
   logic              is_mmio;
   logic              f3_store_ok;
   logic              aligned;
   logic              illegal;
   logic              ram_we;
   logic              mmio_we;
   logic [3:0]        ram_be;
   logic [31:0]       ram_wdata;
   logic              tick;
   logic              irq_set;
   logic [1:0]        w1c;
   logic [31:0]       gpio_in_ext;
   logic [31:0]       gpio_out_ext;
   logic              unused_addr;

   assign ram_idx     = mem_address[AW+1:2];
   assign mmio_off    = mem_address[7:0];
   assign is_mmio     = mem_address[31];
   assign unused_addr = &{1'b0, mem_address[30:AW+2]};

   // Store legality and RAM lane steering
   always_comb begin
      f3_store_ok = 1'b0;
      aligned     = 1'b0;
      ram_be      = 4'b0000;
      ram_wdata   = mem_data_write;
      case (funct3)
         3'b000: begin
            f3_store_ok = 1'b1;
            aligned     = 1'b1;
            ram_be      = 4'b0001 << mem_address[1:0];
            ram_wdata   = {4{mem_data_write[7:0]}};
         end
         3'b001: begin
            f3_store_ok = 1'b1;
            aligned     = (mem_address[0] == 1'b0);
            ram_be      = mem_address[1] ? 4'b1100 : 4'b0011;
            ram_wdata   = {2{mem_data_write[15:0]}};
         end
         3'b010: begin
            f3_store_ok = 1'b1;
            aligned     = (mem_address[1:0] == 2'b00);
            ram_be      = 4'b1111;
            ram_wdata   = mem_data_write;
         end
         default: begin
            f3_store_ok = 1'b0;
            aligned     = 1'b0;
            ram_be      = 4'b0000;
            ram_wdata   = mem_data_write;
         end
      endcase
   end

   // MMIO accepts only aligned word stores
   assign illegal = mem_write & ~reset &
                    (~f3_store_ok | ~aligned | (is_mmio & (funct3 != 3'b010)));
   assign ram_we  = mem_write & ~reset & ~illegal & ~is_mmio;
   assign mmio_we = mem_write & ~reset & ~illegal & is_mmio;

   assign tick = (presc_cnt_q == prescale_q);

   // Next-state for MMIO registers and timer
   always_comb begin
      gpio_out_d  = gpio_out_q;
      mtime_d     = mtime_q;
      mtimecmp_d  = mtimecmp_q;
      prescale_d  = prescale_q;
      presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
      w1c         = 2'b00;
      irq_set     = 1'b0;

      if (tick) begin
         mtime_d = mtime_q + 32'd1;
         irq_set = ((mtime_q + 32'd1) == mtimecmp_q);
      end else begin
         mtime_d = mtime_q;
      end

      if (mmio_we) begin
         case (mmio_off)
            OFF_GPIO_OUT: gpio_out_d = mem_data_write[GPIO_W-1:0];
            OFF_MTIME: begin
               // Software write wins over the tick and suppresses its compare.
               mtime_d = mem_data_write;
               irq_set = 1'b0;
            end
            OFF_MTIMECMP: mtimecmp_d = mem_data_write;
            OFF_STATUS:   w1c        = mem_data_write[1:0];
            OFF_PRESCALE: begin
               prescale_d  = mem_data_write[15:0];
               presc_cnt_d = 16'd0;
            end
            default: gpio_out_d = gpio_out_q;
         endcase
      end else begin
         w1c = 2'b00;
      end

      // Hardware set has priority over a write-1-to-clear of the same bit
      status_d[0] = irq_set | (status_q[0] & ~w1c[0]);
      status_d[1] = illegal | (status_q[1] & ~w1c[1]);
   end

   // MMIO/timer/status registers with synchronous reset
   always_ff @(posedge clk_in) begin
      if (reset) begin
         gpio_out_q  <= '0;
         gpio_s1_q   <= '0;
         gpio_s2_q   <= '0;
         mtime_q     <= 32'd0;
         mtimecmp_q  <= 32'hFFFF_FFFF;
         prescale_q  <= 16'd0;
         presc_cnt_q <= 16'd0;
         status_q    <= 2'b00;
      end else begin
         gpio_out_q  <= gpio_out_d;
         gpio_s1_q   <= gpio_in;
         gpio_s2_q   <= gpio_s1_q;
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         prescale_q  <= prescale_d;
         presc_cnt_q <= presc_cnt_d;
         status_q    <= status_d;
      end
   end

   // Data RAM, byte-lane writes, contents not reset
   always_ff @(posedge clk_in) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_be[b]) begin
               ram_q[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
         end
      end
   end

   // Combinational read mux returning the raw aligned word
   always_comb begin
      gpio_in_ext                 = 32'd0;
      gpio_in_ext[GPIO_W-1:0]     = gpio_s2_q;
      gpio_out_ext                = 32'd0;
      gpio_out_ext[GPIO_W-1:0]    = gpio_out_q;
      chosen_read_data            = 32'd0;
      if (!mem_read) begin
         chosen_read_data = 32'd0;
      end else if (!is_mmio) begin
         chosen_read_data = ram_q[ram_idx];
      end else begin
         case (mmio_off)
            OFF_GPIO_OUT: chosen_read_data = gpio_out_ext;
            OFF_GPIO_IN:  chosen_read_data = gpio_in_ext;
            OFF_MTIME:    chosen_read_data = mtime_q;
            OFF_MTIMECMP: chosen_read_data = mtimecmp_q;
            OFF_STATUS:   chosen_read_data = {30'd0, status_q};
            OFF_PRESCALE: chosen_read_data = {16'd0, prescale_q};
            default:      chosen_read_data = 32'd0;
         endcase
      end
   end

   assign gpio_out       = gpio_out_q;
   assign timer_irq      = status_q[0];
   assign misaligned_err = status_q[1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM lanes, store legality, GPIO sync,
// timer compare/W1C races and mid-run reset.
module tb_data_mem_responder;

   logic        clk_in = 1'b0;
   logic        reset;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_data_write;
   logic [2:0]  funct3;
   logic [31:0] chosen_read_data;
   logic [15:0] gpio_in;
   logic [15:0] gpio_out;
   logic        timer_irq;
   logic        misaligned_err;

   int err_cnt = 0;
   int chk_cnt = 0;
   logic [31:0] rd;

   localparam logic [31:0] A_GPIO_OUT = 32'h8000_0000;
   localparam logic [31:0] A_GPIO_IN  = 32'h8000_0004;
   localparam logic [31:0] A_MTIME    = 32'h8000_0008;
   localparam logic [31:0] A_MTIMECMP = 32'h8000_000C;
   localparam logic [31:0] A_STATUS   = 32'h8000_0010;
   localparam logic [31:0] A_PRESCALE = 32'h8000_0014;

   data_mem_responder dut (
      .clk_in          (clk_in),
      .reset           (reset),
      .mem_address     (mem_address),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_data_write  (mem_data_write),
      .funct3          (funct3),
      .chosen_read_data(chosen_read_data),
      .gpio_in         (gpio_in),
      .gpio_out        (gpio_out),
      .timer_irq       (timer_irq),
      .misaligned_err  (misaligned_err)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      mem_address    = a;
      mem_data_write = d;
      funct3         = f3;
      mem_write      = 1'b1;
      @(posedge clk_in);
      #1;
      mem_write      = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, output logic [31:0] d);
      mem_address = a;
      mem_read    = 1'b1;
      #1;
      d           = chosen_read_data;
      mem_read    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   initial begin
      reset = 1'b1; mem_address = 32'd0; mem_read = 1'b0; mem_write = 1'b0;
      mem_data_write = 32'd0; funct3 = 3'b010; gpio_in = 16'h0000;
      idle(2);
      reset = 1'b0;

      // Reset state
      check("rst_gpio_out", {16'd0, gpio_out}, 32'd0);
      check("rst_irq", {31'd0, timer_irq}, 32'd0);
      check("rst_err", {31'd0, misaligned_err}, 32'd0);
      load(A_MTIMECMP, rd); check("rst_mtimecmp", rd, 32'hFFFF_FFFF);
      load(A_PRESCALE, rd); check("rst_prescale", rd, 32'd0);

      // Stores then loads
      store(32'h10, 32'h1122_3344, 3'b010);
      store(32'h11, 32'h0000_00AA, 3'b000);
      load(32'h10, rd); check("sb_merge", rd, 32'h1122_AA44);
      store(32'h12, 32'h0000_BEEF, 3'b001);
      load(32'h10, rd); check("sh_merge", rd, 32'hBEEF_AA44);
      load(32'h1010, rd); check("ram_wrap", rd, 32'hBEEF_AA44);
      mem_address = 32'h10; #1;
      check("no_read_zero", chosen_read_data, 32'd0);
      load(32'h8000_0018, rd); check("mmio_unmapped", rd, 32'd0);

      // Misaligned and illegal stores
      store(32'h20, 32'h1234_5678, 3'b010);
      store(32'h22, 32'hFFFF_FFFF, 3'b010);
      load(32'h20, rd); check("misal_sw_ram", rd, 32'h1234_5678);
      check("misal_sw_err", {31'd0, misaligned_err}, 32'd1);
      store(A_STATUS, 32'h2, 3'b010);
      check("err_w1c", {31'd0, misaligned_err}, 32'd0);
      store(32'h20, 32'h0000_00EE, 3'b100);
      load(32'h20, rd); check("bad_f3_ram", rd, 32'h1234_5678);
      check("bad_f3_err", {31'd0, misaligned_err}, 32'd1);
      store(32'h21, 32'h0000_00EE, 3'b000);
      load(32'h20, rd); check("sb_lane1", rd, 32'h1234_EE78);
      store(A_STATUS, 32'h2, 3'b010);
      store(32'h8000_0020, 32'h5, 3'b010);
      check("unmapped_wr_noerr", {31'd0, misaligned_err}, 32'd0);

      // GPIO
      store(A_GPIO_OUT, 32'h0000_A5A5, 3'b010);
      check("gpio_out_sw", {16'd0, gpio_out}, 32'h0000_A5A5);
      gpio_in = 16'h0F0F;
      idle(1);
      load(A_GPIO_IN, rd); check("gpio_in_1edge", rd, 32'd0);
      idle(1);
      load(A_GPIO_IN, rd); check("gpio_in_2edge", rd, 32'h0000_0F0F);
      store(A_GPIO_OUT, 32'h0000_0011, 3'b000);
      check("gpio_sb_unchanged", {16'd0, gpio_out}, 32'h0000_A5A5);
      check("gpio_sb_err", {31'd0, misaligned_err}, 32'd1);

      // Timer: counter cleared on the PRESCALE write edge, ticks every 4 edges
      store(A_PRESCALE, 32'd3, 3'b010);
      store(A_MTIMECMP, 32'd2, 3'b010);
      store(A_MTIME, 32'd0, 3'b010);
      idle(1);
      load(A_MTIME, rd); check("mtime_t3", rd, 32'd0);
      idle(1);
      load(A_MTIME, rd); check("mtime_t4", rd, 32'd1);
      check("irq_t4", {31'd0, timer_irq}, 32'd0);
      idle(3);
      load(A_MTIME, rd); check("mtime_t7", rd, 32'd1);
      check("irq_t7", {31'd0, timer_irq}, 32'd0);
      idle(1);
      load(A_MTIME, rd); check("mtime_t8", rd, 32'd2);
      check("irq_t8", {31'd0, timer_irq}, 32'd1);
      store(A_STATUS, 32'h1, 3'b010);
      check("irq_w1c", {31'd0, timer_irq}, 32'd0);
      store(A_MTIME, 32'd1, 3'b010);
      idle(1);
      store(A_STATUS, 32'h1, 3'b010);
      load(A_MTIME, rd); check("mtime_race", rd, 32'd2);
      check("irq_set_beats_w1c", {31'd0, timer_irq}, 32'd1);

      // Reset mid-run, with a store dropped in the reset cycle
      store(A_GPIO_OUT, 32'h0000_FFFF, 3'b010);
      store(A_MTIME, 32'd500, 3'b010);
      load(A_MTIME, rd); check("pre_rst_mtime", rd, 32'd500);
      check("pre_rst_gpio", {16'd0, gpio_out}, 32'h0000_FFFF);
      reset = 1'b1;
      store(A_GPIO_OUT, 32'h0000_1234, 3'b010);
      reset = 1'b0;
      check("mid_rst_gpio", {16'd0, gpio_out}, 32'd0);
      check("mid_rst_irq", {31'd0, timer_irq}, 32'd0);
      check("mid_rst_err", {31'd0, misaligned_err}, 32'd0);
      load(A_MTIME, rd); check("mid_rst_mtime", rd, 32'd0);
      load(A_MTIMECMP, rd); check("mid_rst_mtimecmp", rd, 32'hFFFF_FFFF);
      load(A_PRESCALE, rd); check("mid_rst_prescale", rd, 32'd0);
      load(A_STATUS, rd); check("mid_rst_status", rd, 32'd0);
      load(A_GPIO_IN, rd); check("mid_rst_gpio_in", rd, 32'd0);
      load(32'h10, rd); check("ram_survives_rst", rd, 32'hBEEF_AA44);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
